// File: rtl/arbl2_req_rr.sv
// arbl2_req_rr: round-robin arbiter of NREQ L2 request ports into one directory channel through a 2-entry skid FIFO.
// Optional ARBL2_PERF_EN adds saturating per-slice grant counters.
module arbl2_req_rr #(
   parameter int NREQ    = 2,
   parameter int DATA_W  = 64,
   parameter int NID_LSB = 3,
   parameter int IDX_W   = $clog2(NREQ),
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_retry,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic                   out_valid,
   input  logic                   out_retry,
   output logic [DATA_W-1:0]      out_data
`ifdef ARBL2_PERF_EN
   ,
   input  logic                   perf_clear,
   output logic [NREQ*CNT_W-1:0]  perf_gnt_cnt
`endif
);
   logic [IDX_W-1:0]  rr_ptr, win, idx;
   logic [1:0]        cnt;
   logic [DATA_W-1:0] mem [2];
   logic              rd_ptr, wr_ptr, acc, deq;
   logic [DATA_W-1:0] win_data;
   // Scan from farthest to nearest so the nearest valid slice after rr_ptr wins.
   always_comb begin
      win = rr_ptr;
      idx = rr_ptr;
      for (int k = NREQ; k >= 1; k--) begin
         idx = rr_ptr + IDX_W'(k);
         if (req_valid[idx]) win = idx;
      end
   end
   always_comb begin
      win_data = req_data[win*DATA_W +: DATA_W];
      win_data[NID_LSB +: IDX_W] = win;
   end
   always_comb begin
      req_retry = '0;
      for (int i = 0; i < NREQ; i++)
         req_retry[i] = req_valid[i] && (cnt == 2'd2 || win != IDX_W'(i));
   end
   assign acc       = (|req_valid) && cnt != 2'd2;
   assign out_valid = cnt != 2'd0;
   assign deq       = out_valid && !out_retry;
   assign out_data  = mem[rd_ptr];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
         rr_ptr <= IDX_W'(NREQ-1);
      end else begin
         if (acc) begin
            mem[wr_ptr] <= win_data;
            wr_ptr      <= ~wr_ptr;
            rr_ptr      <= win;
         end
         if (deq) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, acc} - {1'b0, deq};
      end
   end
`ifdef ARBL2_PERF_EN
   logic [NREQ-1:0][CNT_W-1:0] gnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) gnt <= '0;
      else if (perf_clear) gnt <= '0;
      else if (acc && gnt[win] != '1) gnt[win] <= gnt[win] + 1'b1;
   end
   assign perf_gnt_cnt = gnt;
`endif
endmodule

// File: tb/tb_arbl2_req_rr.sv
// tb_arbl2_req_rr: directed scoreboard bench for arbl2_req_rr with NREQ=4, 16-bit payload, nid field at [4:3].
module tb_arbl2_req_rr;
   logic        clk, reset, out_valid, out_retry, perf_clear;
   logic [3:0]  req_valid, req_retry;
   logic [63:0] req_data;
   logic [15:0] out_data, mx;
   logic [11:0] perf_gnt_cnt;
   logic [15:0] sb [$];
   int          left [4], seq [4], total, bad;
   bit          tk [4];

   arbl2_req_rr #(.NREQ(4), .DATA_W(16), .NID_LSB(3), .IDX_W(2), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_retry(req_retry),
      .req_data(req_data), .out_valid(out_valid), .out_retry(out_retry), .out_data(out_data)
`ifdef ARBL2_PERF_EN
      , .perf_clear(perf_clear), .perf_gnt_cnt(perf_gnt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mk(int s, int n);
      return {4'hA, 2'(s), 2'(n), 8'hFF};
   endfunction
   // nid field [4:3] replaced by the slice index, everything else untouched
   function automatic logic [15:0] ex(int s, int n);
      return {4'hA, 2'(s), 2'(n), 3'b111, 2'(s), 3'b111};
   endfunction

   task automatic chk(string name, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, a, e);
      end
   endtask

   task automatic drive();
      for (int s = 0; s < 4; s++) begin
         req_valid[s] = left[s] > 0;
         req_data[s*16 +: 16] = mk(s, seq[s]);
      end
   endtask

   task automatic cyc(int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int s = 0; s < 4; s++) tk[s] = req_valid[s] && !req_retry[s];
         @(posedge clk);
         #1;
         for (int s = 0; s < 4; s++) if (tk[s]) begin
            seq[s]++;
            left[s]--;
         end
         drive();
         #1;
      end
   endtask

   task automatic rst();
      reset = 1'b0;
      for (int s = 0; s < 4; s++) begin
         left[s] = 0;
         seq[s]  = 0;
      end
      sb.delete();
      out_retry  = 1'b0;
      perf_clear = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) cyc(1);
      cyc(3);
      chk(name, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && !out_retry) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL extra_beat got=%h exp=none", out_data);
         end else begin
            mx = sb.pop_front();
            if (out_data !== mx) begin
               bad++;
               $display("FAIL beat_order got=%h exp=%h", out_data, mx);
            end
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_retry", req_retry, 0);
      // single beat from slice 0, one-cycle latency, no bypass
      left[0] = 1;
      sb.push_back(ex(0, 0));
      drive();
      #1;
      chk("t1_no_bypass", out_valid, 0);
      chk("t1_winner_not_retried", req_retry, 0);
      cyc(1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, ex(0, 0));
      cyc(1);
      chk("t1_empty_again", out_valid, 0);
      drain("t1_drain");
      // all four slices continuously valid: 0,1,2,3,0,1,...
      rst();
      for (int n = 0; n < 3; n++)
         for (int s = 0; s < 4; s++) sb.push_back(ex(s, n));
      for (int s = 0; s < 4; s++) left[s] = 3;
      drive();
      #1;
      chk("t2_retry_losers", req_retry, 4'b1110);
      drain("t2_rr_drain");
      // output blocked: fill, freeze, then release
      rst();
      out_retry = 1'b1;
      left[0] = 2;
      left[1] = 2;
      sb.push_back(ex(0, 0));
      sb.push_back(ex(1, 0));
      sb.push_back(ex(0, 1));
      sb.push_back(ex(1, 1));
      drive();
      #1;
      cyc(2);
      chk("t3_full_retry", req_retry, 4'b0011);
      chk("t3_head", out_data, ex(0, 0));
      cyc(1);
      chk("t3_head_stable", out_data, ex(0, 0));
      chk("t3_still_full", req_retry, 4'b0011);
      out_retry = 1'b0;
      drain("t3_drain");
      // full FIFO with a dequeue pending: no accept this cycle, accept next
      rst();
      out_retry = 1'b1;
      left[0] = 4;
      for (int n = 0; n < 4; n++) sb.push_back(ex(0, n));
      drive();
      #1;
      cyc(2);
      chk("t4_full_retry", req_retry, 4'b0001);
      out_retry = 1'b0;
      #1;
      chk("t4_retry_during_deq", req_retry, 4'b0001);
      cyc(1);
      chk("t4_accept_resumes", req_retry, 4'b0000);
      chk("t4_head", out_data, ex(0, 1));
      drain("t4_drain");
      // reset asserted with the FIFO full
      rst();
      out_retry = 1'b1;
      for (int s = 0; s < 4; s++) left[s] = 2;
      drive();
      #1;
      cyc(2);
      chk("t5_full_before_rst", out_valid, 1);
      reset = 1'b0;
      #1;
      chk("t5_async_clear", out_valid, 0);
      rst();
      left[0] = 1;
      left[1] = 1;
      sb.push_back(ex(0, 0));
      sb.push_back(ex(1, 0));
      drive();
      #1;
      chk("t5_slice0_first", req_retry, 4'b0010);
      drain("t5_drain");
`ifdef ARBL2_PERF_EN
      rst();
      left[1] = 5;
      for (int n = 0; n < 5; n++) sb.push_back(ex(1, n));
      drive();
      #1;
      drain("t6_drain");
      chk("t6_cnt1", perf_gnt_cnt[5:3], 5);
      chk("t6_cnt0", perf_gnt_cnt[2:0], 0);
      perf_clear = 1'b1;
      cyc(1);
      perf_clear = 1'b0;
      chk("t6_cleared", perf_gnt_cnt[5:3], 0);
      left[1] = 8;
      for (int n = 5; n < 13; n++) sb.push_back(ex(1, n));
      drive();
      #1;
      drain("t6_drain2");
      chk("t6_saturate", perf_gnt_cnt[5:3], 7);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
